// File: rtl/hood_pkg.sv
// Shared definitions for the range-hood fan sequencer and display blocks.
// State encodings, fan level constants, default durations and helpers.
package hood_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_STANDBY   = 3'd1,
        ST_MENU      = 3'd2,
        ST_LEVEL1    = 3'd3,
        ST_LEVEL2    = 3'd4,
        ST_HURRICANE = 3'd5,
        ST_COOLDOWN  = 3'd6,
        ST_CLEAN     = 3'd7
    } hood_state_t;

    localparam logic [1:0] FAN_OFF       = 2'd0;
    localparam logic [1:0] FAN_L1        = 2'd1;
    localparam logic [1:0] FAN_L2        = 2'd2;
    localparam logic [1:0] FAN_HURRICANE = 2'd3;

    localparam int DEF_CLK_FREQ      = 100_000_000;
    localparam int DEF_HURRICANE_SEC = 60;
    localparam int DEF_CLEAN_SEC     = 180;

    function automatic logic [1:0] fan_for(hood_state_t s);
        logic [1:0] f;
        f = FAN_OFF;
        case (s)
            ST_LEVEL1:    f = FAN_L1;
            ST_LEVEL2:    f = FAN_L2;
            ST_COOLDOWN:  f = FAN_L2;
            ST_HURRICANE: f = FAN_HURRICANE;
            default:      f = FAN_OFF;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/hood_mode_controller_sec_tick_gen.sv
// One-second tick prescaler: counts 0..CLK_FREQ-1, tick high at the top.
// Ports: clk, reset (async, active-low), clear (sync restart), tick.
module sec_tick_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_FREQ - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hood_mode_controller.sv
// Range-hood fan mode sequencer with hurricane, cooldown and self-clean timers.
// Ports: clk, reset (async low), power_on, key_* pulses; fan_level, mode,
//        remaining_sec, hurricane_used, clean_active (all registered).
module hood_mode_controller
    import hood_pkg::*;
#(
    parameter int CLK_FREQ      = DEF_CLK_FREQ,
    parameter int HURRICANE_SEC = DEF_HURRICANE_SEC,
    parameter int CLEAN_SEC     = DEF_CLEAN_SEC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_on,
    input  logic       key_menu,
    input  logic       key_l1,
    input  logic       key_l2,
    input  logic       key_l3,
    input  logic       key_clean,
    output logic [1:0] fan_level,
    output logic [2:0] mode,
    output logic [7:0] remaining_sec,
    output logic       hurricane_used,
    output logic       clean_active
);

    localparam logic [7:0] HUR_LOAD   = 8'(HURRICANE_SEC);
    localparam logic [7:0] CLEAN_LOAD = 8'(CLEAN_SEC);

    hood_state_t state, state_nx;
    logic [7:0]  rem_nx;
    logic        used_nx;
    logic        clear;
    logic        tick;
    logic        last_tick;

    sec_tick_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .tick (tick)
    );

    // The tick that takes the count from 1 to 0 also performs the exit.
    assign last_tick = tick && (remaining_sec <= 8'd1);

    always_comb begin
        state_nx = state;
        rem_nx   = remaining_sec;
        used_nx  = hurricane_used;
        clear    = 1'b0;
        if (!power_on) begin
            state_nx = ST_OFF;
            rem_nx   = 8'd0;
            used_nx  = 1'b0;
            clear    = 1'b1;
        end else begin
            case (state)
                ST_OFF: state_nx = ST_STANDBY;
                ST_STANDBY: begin
                    if (key_menu) state_nx = ST_MENU;
                end
                ST_MENU: begin
                    if (key_menu) begin
                        state_nx = ST_STANDBY;
                    end else if (key_l3 && !hurricane_used) begin
                        state_nx = ST_HURRICANE;
                        rem_nx   = HUR_LOAD;
                        used_nx  = 1'b1;
                        clear    = 1'b1;
                    end else if (key_l2) begin
                        state_nx = ST_LEVEL2;
                    end else if (key_l1) begin
                        state_nx = ST_LEVEL1;
                    end else if (key_clean) begin
                        state_nx = ST_CLEAN;
                        rem_nx   = CLEAN_LOAD;
                        clear    = 1'b1;
                    end
                end
                ST_LEVEL1: begin
                    if (key_menu)    state_nx = ST_STANDBY;
                    else if (key_l2) state_nx = ST_LEVEL2;
                end
                ST_LEVEL2: begin
                    if (key_menu)    state_nx = ST_STANDBY;
                    else if (key_l1) state_nx = ST_LEVEL1;
                end
                ST_HURRICANE: begin
                    // Expiry beats a coincident menu key.
                    if (last_tick) begin
                        state_nx = ST_LEVEL2;
                        rem_nx   = 8'd0;
                    end else if (key_menu) begin
                        state_nx = ST_COOLDOWN;
                        rem_nx   = HUR_LOAD;
                        clear    = 1'b1;
                    end else if (tick) begin
                        rem_nx = remaining_sec - 8'd1;
                    end
                end
                ST_COOLDOWN, ST_CLEAN: begin
                    if (last_tick) begin
                        state_nx = ST_STANDBY;
                        rem_nx   = 8'd0;
                    end else if (tick) begin
                        rem_nx = remaining_sec - 8'd1;
                    end
                end
                default: state_nx = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_OFF;
            remaining_sec  <= 8'd0;
            hurricane_used <= 1'b0;
            fan_level      <= FAN_OFF;
            clean_active   <= 1'b0;
        end else begin
            state          <= state_nx;
            remaining_sec  <= rem_nx;
            hurricane_used <= used_nx;
            fan_level      <= fan_for(state_nx);
            clean_active   <= (state_nx == ST_CLEAN);
        end
    end

    assign mode = state;

endmodule
